dt_skel: RTL and testbench
==========================

DT_SKEL -- requirements
Module: dt_skel

Interface
REQ-001 SHALL have clock/reset: clk input 1, rising-edge clock; reset input 1, asynchronous, active-high.
REQ-002 SHALL have: start input 1, one-cycle pulse from the distance-transform stage once its result memory is complete.
REQ-003 SHALL have: res_rd output 1, read strobe to the 16384x8 result RAM; res_addr output 14, {row[6:0],col[6:0]}; res_di input 8, read data.
REQ-004 SHALL have: skl_wr output 1, write strobe; skl_addr output 10, {row[6:0],word[2:0]}; skl_do output 16, packed skeleton word.
REQ-005 SHALL have: busy output 1, high while a scan runs; done output 1, high from scan end until next accepted start.

Function
REQ-006 SHALL scan a 128x128 distance image; pixel p(r,c) is skeleton iff p!=0 and p>=N, S, W and E 4-neighbours (unsigned compare).
REQ-007 SHALL treat neighbours outside rows/cols 0..127 as value 0.
REQ-008 SHALL count ties (p equal to a neighbour) as skeleton.
REQ-009 SHALL pack 16 pixels per word: skl_do bit 15 = col 16*word, bit 0 = col 16*word+15.
REQ-010 SHALL process words in ascending skl_addr order, 0..1023.
REQ-011 SHALL use states IDLE, READ, DRAIN, WRITE, DONE.
REQ-012 IDLE/DONE -> READ on start sampled high; start in READ/DRAIN/WRITE SHALL be ignored.
REQ-013 READ SHALL last exactly 50 cycles per word, one read slot per cycle, in order: row r cols c0-1..c0+16 (18 slots), row r-1 cols c0..c0+15 (16), row r+1 cols c0..c0+15 (16).
REQ-014 res_di SHALL be valid the cycle after its slot; capture lags issue by one cycle.
REQ-015 Slots addressing outside the image SHALL drive res_rd=0, res_addr=0, and capture value 0; slot timing unchanged.
REQ-016 READ -> DRAIN (1 cycle, last capture) -> WRITE (1 cycle: skl_wr=1, skl_addr, skl_do valid).
REQ-017 WRITE -> READ for next word; after word 1023 WRITE -> DONE.
REQ-018 Per-word period SHALL be exactly 52 cycles; with start sampled at cycle 0, word k issues in cycles 52k+1..52k+50, writes in 52k+52.
REQ-019 done SHALL rise in cycle 53249 and hold; busy SHALL be high cycles 1..53248.
REQ-020 res_rd SHALL be 0 outside READ; skl_wr SHALL be 1 only in WRITE.
REQ-021 Neighbour compare SHALL be 8-bit unsigned; no saturation or arithmetic on pixel values.

Reset
REQ-022 reset high SHALL immediately force state IDLE, res_rd=0, res_addr=0, skl_wr=0, skl_addr=0, skl_do=0, busy=0, done=0, all capture registers 0.
REQ-023 reset asserted mid-scan SHALL abort without further writes; next start SHALL restart at word 0.
REQ-024 start coincident with reset SHALL be ignored.

Verification
REQ-025 All-zero result RAM, start -> 1024 writes of 16'h0000 at addrs 0..1023, one per 52 cycles, done high in cycle 53249.
REQ-026 Single pixel value 1 at (5,37), rest 0 -> addr 42 written 16'h0400; all other words 16'h0000.
REQ-027 Pixels (20,0) and (20,1) both 3, rest 0 -> addr 160 written 16'hC000 (tie rule, left border as 0).
REQ-028 Row 10 col c = c+1, rest 0 -> addr 87 written 16'h0001, addrs 80..86 16'h0000 (word-boundary neighbour at col 16k).
REQ-029 reset pulsed during READ of word 300 -> outputs 0 same cycle, no write to addr 300; new start -> first write addr 0 in cycle 52.
REQ-030 start pulsed again at cycle 1000 of a scan -> no effect; done still rises in cycle 53249.

Source files
------------

// File: rtl/dt_skel.sv
// dt_skel: skeleton extraction from a 128x128 distance image.
// A pixel is skeleton when it is non-zero and not smaller than any of its
// four direct neighbours (neighbours outside the image read as 0).
// Each 16-pixel output word is built from a 50-read window:
//   row r   cols c0-1..c0+16 (centre row plus W/E guard pixels)
//   row r-1 cols c0..c0+15   (north neighbours)
//   row r+1 cols c0..c0+15   (south neighbours)
// The window is followed by one drain cycle for the last read and one write cycle.
module dt_skel (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        res_rd,
  output logic [13:0] res_addr,
  input  logic [7:0]  res_di,
  output logic        skl_wr,
  output logic [9:0]  skl_addr,
  output logic [15:0] skl_do,
  output logic        busy,
  output logic        done
);

  localparam int SLOTS = 50;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state_reg;
  state_t      state_next;

  // Read slot within the current word's window (0..49 while reading).
  logic [5:0]  slot_reg;
  // Current output word address {row[6:0], word[2:0]}.
  logic [9:0]  word_reg;

  // Capture pipeline: what was issued last cycle, and where it lands.
  logic        cap_en_reg;
  logic        cap_vld_reg;
  logic [5:0]  cap_idx_reg;
  logic [7:0]  cap_reg [SLOTS];

  logic [6:0]  cur_row;
  logic [6:0]  cur_c0;
  logic [7:0]  slot_row;
  logic [8:0]  slot_col;
  logic        slot_in;
  logic [15:0] skel_bits;

  assign cur_row = word_reg[9:3];
  assign cur_c0  = {word_reg[2:0], 4'b0000};

  // Map the current slot to an image coordinate; the row/col arithmetic
  // is one bit wider so that -1 and 128 both show up as out of range.
  always_comb begin
    slot_row = {1'b0, cur_row};
    slot_col = '0;
    if (slot_reg < 6'd18) begin
      slot_row = {1'b0, cur_row};
      slot_col = {2'b00, cur_c0} + {3'b000, slot_reg} - 9'd1;
    end else if (slot_reg < 6'd34) begin
      slot_row = {1'b0, cur_row} - 8'd1;
      slot_col = {2'b00, cur_c0} + {3'b000, slot_reg} - 9'd18;
    end else begin
      slot_row = {1'b0, cur_row} + 8'd1;
      slot_col = {2'b00, cur_c0} + {3'b000, slot_reg} - 9'd34;
    end
    slot_in = (slot_row[7] == 1'b0) && (slot_col[8:7] == 2'b00);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; start only matters while idle or finished.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = READ;
      READ:    if (slot_reg == 6'(SLOTS - 1)) state_next = DRAIN;
      DRAIN:   state_next = WRITE;
      WRITE:   state_next = (word_reg == 10'd1023) ? DONE : READ;
      DONE:    if (start) state_next = READ;
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the registered state; everything is zero outside
  // the cycles where it is meaningful, so reset clears outputs at once.
  always_comb begin
    res_rd   = 1'b0;
    res_addr = '0;
    skl_wr   = 1'b0;
    skl_addr = '0;
    skl_do   = '0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_reg)
      READ: begin
        busy = 1'b1;
        if (slot_in) begin
          res_rd   = 1'b1;
          res_addr = {slot_row[6:0], slot_col[6:0]};
        end
      end
      DRAIN: begin
        busy = 1'b1;
      end
      WRITE: begin
        busy     = 1'b1;
        skl_wr   = 1'b1;
        skl_addr = word_reg;
        skl_do   = skel_bits;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Slot and word counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_reg <= '0;
      word_reg <= '0;
    end else begin
      slot_reg <= (state_reg == READ) ? slot_reg + 6'd1 : 6'd0;
      if ((state_reg == IDLE || state_reg == DONE) && start) begin
        word_reg <= '0;
      end else if (state_reg == WRITE) begin
        word_reg <= word_reg + 10'd1;
      end
    end
  end

  // Remember which slot was issued so its data can be stored next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_en_reg  <= 1'b0;
      cap_vld_reg <= 1'b0;
      cap_idx_reg <= '0;
    end else begin
      cap_en_reg  <= (state_reg == READ);
      cap_vld_reg <= res_rd;
      cap_idx_reg <= slot_reg;
    end
  end

  // Window capture; slots that fell outside the image store 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SLOTS; i++) begin
        cap_reg[i] <= '0;
      end
    end else if (cap_en_reg) begin
      for (int i = 0; i < SLOTS; i++) begin
        if (cap_idx_reg == 6'(i)) begin
          cap_reg[i] <= cap_vld_reg ? res_di : 8'd0;
        end
      end
    end
  end

  // Skeleton decision per column; leftmost column goes to bit 15.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_pix
      logic [7:0] p_c;
      logic [7:0] p_w;
      logic [7:0] p_e;
      logic [7:0] p_n;
      logic [7:0] p_s;
      assign p_c = cap_reg[gi + 1];
      assign p_w = cap_reg[gi];
      assign p_e = cap_reg[gi + 2];
      assign p_n = cap_reg[18 + gi];
      assign p_s = cap_reg[34 + gi];
      assign skel_bits[15 - gi] = (p_c != 8'd0) && (p_c >= p_w) && (p_c >= p_e) &&
                                  (p_c >= p_n) && (p_c >= p_s);
    end
  endgenerate

endmodule

// File: tb/tb_dt_skel.sv
// tb_dt_skel: randomized scoreboard bench for dt_skel with a result-RAM model.
module tb_dt_skel;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        res_rd;
  logic [13:0] res_addr;
  logic [7:0]  res_di;
  logic        skl_wr;
  logic [9:0]  skl_addr;
  logic [15:0] skl_do;
  logic        busy;
  logic        done;

  dt_skel dut (
    .clk(clk), .reset(reset), .start(start),
    .res_rd(res_rd), .res_addr(res_addr), .res_di(res_di),
    .skl_wr(skl_wr), .skl_addr(skl_addr), .skl_do(skl_do),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          t;
    logic [9:0]  a;
    logic [15:0] d;
  } wr_t;

  logic [7:0] img [16384];
  wr_t        sb_q [$];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         scan_t0 = 0;
  bit         scan_on = 1'b0;
  bit         fixed_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Result RAM: one-cycle read latency; garbage on the bus when not read.
  always @(posedge clk) res_di <= res_rd ? img[res_addr] : 8'($urandom);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30)
        $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] px(input int r, input int c);
    if (r < 0 || r > 127 || c < 0 || c > 127) return 8'd0;
    return img[r * 128 + c];
  endfunction

  // Reference: skeleton word straight from the pixel rule.
  function automatic logic [15:0] ref_word(input int r, input int w);
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) begin
      int c;
      logic [7:0] p;
      c = 16 * w + i;
      p = px(r, c);
      if (p != 0 && p >= px(r - 1, c) && p >= px(r + 1, c) &&
          p >= px(r, c - 1) && p >= px(r, c + 1))
        v[15 - i] = 1'b1;
    end
    return v;
  endfunction

  task automatic start_scan();
    @(negedge clk);
    start   = 1'b1;
    scan_t0 = cyc;
    scan_on = 1'b1;
    for (int k = 0; k < 1024; k++) begin
      wr_t e;
      e.t = scan_t0 + 52 * k + 52;
      e.a = 10'(k);
      e.d = ref_word(k / 8, k % 8);
      sb_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_res_rd"}, 32'(res_rd), 32'd0);
    chk({tag, "_res_addr"}, 32'(res_addr), 32'd0);
    chk({tag, "_skl_wr"}, 32'(skl_wr), 32'd0);
    chk({tag, "_skl_addr"}, 32'(skl_addr), 32'd0);
    chk({tag, "_skl_do"}, 32'(skl_do), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // Monitor: read sequence, busy/done timing and scoreboard of writes.
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      int rel;
      bit exp_rd;
      int exp_addr;
      bit exp_busy;
      bit exp_done;
      rel      = cyc - scan_t0;
      exp_rd   = 1'b0;
      exp_addr = 0;
      exp_busy = scan_on && rel >= 1 && rel <= 53248;
      exp_done = scan_on && rel >= 53249;
      if (exp_busy) begin
        int k;
        int s;
        k = (rel - 1) / 52;
        s = (rel - 1) % 52;
        if (s < 50) begin
          int rr;
          int cc;
          if (s < 18) begin
            rr = k / 8; cc = (k % 8) * 16 - 1 + s;
          end else if (s < 34) begin
            rr = k / 8 - 1; cc = (k % 8) * 16 + s - 18;
          end else begin
            rr = k / 8 + 1; cc = (k % 8) * 16 + s - 34;
          end
          if (rr >= 0 && rr < 128 && cc >= 0 && cc < 128) begin
            exp_rd   = 1'b1;
            exp_addr = rr * 128 + cc;
          end
        end
      end
      chk("res_rd", 32'(res_rd), 32'(exp_rd));
      chk("res_addr", 32'(res_addr), 32'(exp_addr));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'(exp_done));
      if (skl_wr === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("wr_unexpected_addr", 32'(skl_addr), 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = sb_q.pop_front();
          chk("wr_cycle", 32'(cyc), 32'(e.t));
          chk("wr_addr", 32'(skl_addr), 32'(e.a));
          chk("wr_data", 32'(skl_do), 32'(e.d));
          if (fixed_on) begin
            if (skl_addr == 10'd42) chk("pix_5_37", 32'(skl_do), 32'h0400);
            if (skl_addr == 10'd160) chk("tie_left_border", 32'(skl_do), 32'hC000);
            if (skl_addr == 10'd87) chk("ramp_last_col", 32'(skl_do), 32'h0001);
            if (skl_addr >= 10'd80 && skl_addr <= 10'd86) chk("ramp_zero", 32'(skl_do), 32'h0000);
          end
        end
      end else if (sb_q.size() != 0 && sb_q[0].t == cyc) begin
        wr_t e;
        e = sb_q.pop_front();
        chk("wr_missing", 32'(skl_wr), 32'd1);
      end
    end
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 16384; i++) img[i] = 8'd0;

    // Reset state, and a start coincident with reset must be ignored.
    repeat (2) @(negedge clk);
    start = 1'b1;
    #1;
    chk_zero_outputs("reset");
    @(negedge clk);
    start = 1'b0;
    #2;
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Scan A: random small values (many ties), aborted in word 3.
    for (int i = 0; i < 16384; i++) img[i] = 8'($urandom_range(0, 4));
    start_scan();
    while (cyc < scan_t0 + 52 * 3 + 10) @(negedge clk);
    #2;
    reset   = 1'b1;
    scan_on = 1'b0;
    chk("abort_writes_seen", 32'(sb_q.size()), 32'd1021);
    sb_q.delete();
    #1;
    chk_zero_outputs("abort");
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
    repeat (60) @(negedge clk);

    // Scan B: fixed patterns in the upper rows, random data below.
    for (int i = 0; i < 16384; i++) img[i] = 8'd0;
    img[5 * 128 + 37] = 8'd1;
    img[20 * 128 + 0] = 8'd3;
    img[20 * 128 + 1] = 8'd3;
    for (int c = 0; c < 128; c++) img[10 * 128 + c] = 8'(c + 1);
    for (int r = 64; r < 100; r++)
      for (int c = 0; c < 128; c++) img[r * 128 + c] = 8'($urandom_range(0, 5));
    for (int r = 100; r < 128; r++)
      for (int c = 0; c < 128; c++) img[r * 128 + c] = 8'($urandom_range(0, 255));
    fixed_on = 1'b1;
    start_scan();
    // Second start mid-scan has no effect on the schedule.
    while (cyc < scan_t0 + 1000) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (done !== 1'b1 && cyc < scan_t0 + 53400) @(negedge clk);
    chk("done_rise_cycle", 32'(cyc - scan_t0), 32'd53249);
    repeat (5) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    chk("done_hold", 32'(done), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
